// File: rtl/pipeline_hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pipeline_hazard_ctrl_pkg
//  Description : Shared definitions for the pipeline hazard controller:
//                instruction opcodes, FSM state encoding and the
//                source-register usage decode. main_control decodes the
//                same opcodes from this package.
//  Revision    : 1.0 - initial release
// ============================================================================
package pipeline_hazard_ctrl_pkg;

   // Opcodes understood by the pipeline; anything else behaves as a NOP.
   localparam logic [5:0] OP_LW  = 6'b100011;
   localparam logic [5:0] OP_SW  = 6'b101011;
   localparam logic [5:0] OP_LUI = 6'b001111;
   localparam logic [5:0] OP_ORI = 6'b001110;
   localparam logic [5:0] OP_MUL = 6'b011010;
   localparam logic [5:0] OP_JR  = 6'b000010;

   // Hazard controller FSM encoding
   localparam int STATE_W = 1;
   typedef logic [STATE_W-1:0] state_t;
   localparam state_t ST_RUN      = 1'b0;
   localparam state_t ST_MUL_WAIT = 1'b1;

   // Which register fields an instruction actually reads
   typedef struct packed {
      logic rs;
      logic rt;
   } src_use_t;

   function automatic src_use_t src_use(input logic [5:0] i_op);
      src_use_t u;
      u = '0;
      case (i_op)
         OP_LW, OP_ORI, OP_JR: u.rs = 1'b1;
         OP_SW, OP_MUL: begin
            u.rs = 1'b1;
            u.rt = 1'b1;
         end
         OP_LUI:  u = '0;
         default: u = '0;
      endcase
      return u;
   endfunction

endpackage : pipeline_hazard_ctrl_pkg
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : pipeline_hazard_ctrl_if
//  Description : Bundle between the pipeline datapath and the hazard
//                controller.
//                master : datapath side - drives ID/EX status, receives
//                         stall/flush/bubble controls and perf counters.
//                slave  : hazard controller side.
//                Signals: id_valid, id_opcode, id_rs, id_rt, ex_valid,
//                ex_mem_read, ex_reg_write, ex_dst, ex_is_mul (to ctrl);
//                pc_stall, ifid_stall, ifid_flush, idex_bubble,
//                idex_stall, exmem_bubble, jr_take, stall_cnt,
//                flush_cnt (from ctrl).
//  Revision    : 1.0 - initial release
// ============================================================================
interface pipeline_hazard_ctrl_if #(
   parameter int CNT_W = 16
);
   logic             id_valid;
   logic [5:0]       id_opcode;
   logic [4:0]       id_rs;
   logic [4:0]       id_rt;
   logic             ex_valid;
   logic             ex_mem_read;
   logic             ex_reg_write;
   logic [4:0]       ex_dst;
   logic             ex_is_mul;

   logic             pc_stall;
   logic             ifid_stall;
   logic             ifid_flush;
   logic             idex_bubble;
   logic             idex_stall;
   logic             exmem_bubble;
   logic             jr_take;
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] flush_cnt;

   modport master (
      output id_valid, id_opcode, id_rs, id_rt,
      output ex_valid, ex_mem_read, ex_reg_write, ex_dst, ex_is_mul,
      input  pc_stall, ifid_stall, ifid_flush, idex_bubble, idex_stall,
      input  exmem_bubble, jr_take, stall_cnt, flush_cnt
   );

   modport slave (
      input  id_valid, id_opcode, id_rs, id_rt,
      input  ex_valid, ex_mem_read, ex_reg_write, ex_dst, ex_is_mul,
      output pc_stall, ifid_stall, ifid_flush, idex_bubble, idex_stall,
      output exmem_bubble, jr_take, stall_cnt, flush_cnt
   );

endinterface : pipeline_hazard_ctrl_if
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl_perf_sat_counter.sv
`default_nettype none
// ============================================================================
//  Module      : perf_sat_counter
//  Description : Saturating event counter. Counts cycles with i_inc=1,
//                sticks at all-ones, synchronous clear.
//                Ports: clk, i_clear, i_inc, o_cnt[CNT_W].
//  Revision    : 1.0 - initial release
// ============================================================================
module perf_sat_counter #(
   parameter int CNT_W = 16
) (
   input  wire logic             clk,
   input  wire logic             i_clear,
   input  wire logic             i_inc,
   output      logic [CNT_W-1:0] o_cnt
);

   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge clk) begin
      if (i_clear) begin
         r_cnt <= '0;
      end else if (i_inc && (r_cnt != '1)) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign o_cnt = r_cnt;

endmodule : perf_sat_counter
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pipeline_hazard_ctrl
//  Description : Sequences the 5-stage pipeline: load-use / jr-source
//                stalls, multiplier freeze of IF/ID/EX, wrong-path squash
//                after jr, saturating stall/flush perf counters.
//                Ports: clk, rst (sync, active high),
//                bus (pipeline_hazard_ctrl_if.slave).
//  Revision    : 1.0 - initial release
// ============================================================================
module pipeline_hazard_ctrl
   import pipeline_hazard_ctrl_pkg::*;
#(
   parameter int MUL_LAT = 3,
   parameter int CNT_W   = 16
) (
   input wire logic              clk,
   input wire logic              rst,
   pipeline_hazard_ctrl_if.slave bus
);

   // Hold count loaded on entry to MUL_WAIT; entry cycle itself is one hold.
   localparam logic [3:0] c_MCNT_INIT = (MUL_LAT > 1) ? 4'(MUL_LAT - 2) : 4'd0;
   localparam bit         c_MUL_HOLDS = (MUL_LAT > 1);

   state_t     r_state, w_state_nxt;
   logic [3:0] r_mcnt,  w_mcnt_nxt;

   src_use_t   w_use;
   logic       w_is_jr;
   logic       w_lu_haz;
   logic       w_jr_haz;
   logic       w_mul_start;
   logic       w_hold;

   logic       w_pc_stall, w_ifid_stall, w_ifid_flush;
   logic       w_idex_bubble, w_idex_stall, w_exmem_bubble, w_jr_take;
   logic [CNT_W-1:0] w_stall_cnt, w_flush_cnt;

   // ---------------------------------------------------------------
   // Hazard detection (register 0 never creates a dependency)
   // ---------------------------------------------------------------
   assign w_use   = src_use(bus.id_opcode);
   assign w_is_jr = bus.id_valid && (bus.id_opcode == OP_JR);

   assign w_lu_haz = bus.id_valid && bus.ex_valid && bus.ex_mem_read &&
                     (bus.ex_dst != 5'd0) &&
                     ((w_use.rs && (bus.id_rs == bus.ex_dst)) ||
                      (w_use.rt && (bus.id_rt == bus.ex_dst)));

   // jr reads rs in ID with no forwarding path, so any in-flight writer stalls
   assign w_jr_haz = w_is_jr && bus.ex_valid && bus.ex_reg_write &&
                     (bus.ex_dst == bus.id_rs) && (bus.id_rs != 5'd0);

   assign w_mul_start = bus.ex_valid && bus.ex_is_mul && c_MUL_HOLDS;

   // ---------------------------------------------------------------
   // FSM: state register
   // ---------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_RUN;
         r_mcnt  <= 4'd0;
      end else begin
         r_state <= w_state_nxt;
         r_mcnt  <= w_mcnt_nxt;
      end
   end

   // ---------------------------------------------------------------
   // FSM: next state
   // ---------------------------------------------------------------
   always_comb begin
      w_state_nxt = r_state;
      w_mcnt_nxt  = r_mcnt;
      case (r_state)
         ST_RUN: begin
            if (w_mul_start) begin
               w_state_nxt = ST_MUL_WAIT;
               w_mcnt_nxt  = c_MCNT_INIT;
            end
         end
         ST_MUL_WAIT: begin
            if (r_mcnt != 4'd0) begin
               w_mcnt_nxt = r_mcnt - 4'd1;
            end else begin
               w_state_nxt = ST_RUN;
            end
         end
         default: begin
            w_state_nxt = ST_RUN;
            w_mcnt_nxt  = 4'd0;
         end
      endcase
   end

   // ---------------------------------------------------------------
   // FSM: outputs. The release cycle of MUL_WAIT (mcnt==0) falls through
   // to the normal hazard / jr evaluation, while the mul still sits in EX
   // without re-triggering a hold.
   // ---------------------------------------------------------------
   assign w_hold = ((r_state == ST_RUN) && w_mul_start) ||
                   ((r_state == ST_MUL_WAIT) && (r_mcnt != 4'd0));

   always_comb begin
      w_pc_stall     = 1'b0;
      w_ifid_stall   = 1'b0;
      w_ifid_flush   = 1'b0;
      w_idex_bubble  = 1'b0;
      w_idex_stall   = 1'b0;
      w_exmem_bubble = 1'b0;
      w_jr_take      = 1'b0;
      if (!rst) begin
         if (w_hold) begin
            w_pc_stall     = 1'b1;
            w_ifid_stall   = 1'b1;
            w_idex_stall   = 1'b1;
            w_exmem_bubble = 1'b1;
         end else if (w_lu_haz || w_jr_haz) begin
            w_pc_stall     = 1'b1;
            w_ifid_stall   = 1'b1;
            w_idex_bubble  = 1'b1;
         end else if (w_is_jr) begin
            w_jr_take      = 1'b1;
            w_ifid_flush   = 1'b1;
         end
      end
   end

   // ---------------------------------------------------------------
   // Performance counters
   // ---------------------------------------------------------------
   perf_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
      .clk     (clk),
      .i_clear (rst),
      .i_inc   (w_pc_stall),
      .o_cnt   (w_stall_cnt)
   );

   perf_sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
      .clk     (clk),
      .i_clear (rst),
      .i_inc   (w_ifid_flush),
      .o_cnt   (w_flush_cnt)
   );

   assign bus.pc_stall     = w_pc_stall;
   assign bus.ifid_stall   = w_ifid_stall;
   assign bus.ifid_flush   = w_ifid_flush;
   assign bus.idex_bubble  = w_idex_bubble;
   assign bus.idex_stall   = w_idex_stall;
   assign bus.exmem_bubble = w_exmem_bubble;
   assign bus.jr_take      = w_jr_take;
   assign bus.stall_cnt    = w_stall_cnt;
   assign bus.flush_cnt    = w_flush_cnt;

endmodule : pipeline_hazard_ctrl
`default_nettype wire
